// File: rtl/ring_osc_meter.sv
// Ring oscillator frequency meter: enables the NAND ring, synchronizes its output,
// and counts rising edges over a fixed gate window after a settle period.
module ring_osc_meter #(
  parameter int GATE_CYCLES   = 1024,
  parameter int SETTLE_CYCLES = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             osc_in,
  output logic             osc_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int GATE_W = $clog2(GATE_CYCLES + 1);
  localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [GATE_W-1:0] GATE_LAST   = GATE_W'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_GATE
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [SET_W-1:0]       r_settle_cnt;
  logic [GATE_W-1:0]      r_gate_cnt;
  logic [CNT_W-1:0]       r_edge_cnt;
  logic                   r_ovf;
  logic                   r_osc_en;
  logic                   r_busy;
  logic                   r_done;
  logic [CNT_W-1:0]       r_count;
  logic                   r_overflow;

  logic                   w_rise;
  logic                   w_cnt_max;
  logic [CNT_W-1:0]       w_edge_next;
  logic                   w_ovf_next;

  // Synchronizer and edge detect run continuously, independent of the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], osc_in};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_rise      = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign w_cnt_max   = &r_edge_cnt;
  assign w_edge_next = r_edge_cnt + CNT_W'(w_rise & ~w_cnt_max);
  assign w_ovf_next  = r_ovf | (w_rise & w_cnt_max);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_settle_cnt <= '0;
      r_gate_cnt   <= '0;
      r_edge_cnt   <= '0;
      r_ovf        <= 1'b0;
      r_osc_en     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            r_state      <= S_SETTLE;
            r_osc_en     <= 1'b1;
            r_busy       <= 1'b1;
            r_settle_cnt <= '0;
            r_edge_cnt   <= '0;
            r_ovf        <= 1'b0;
          end
        end
        S_SETTLE: begin
          if (abort) begin
            r_state    <= S_IDLE;
            r_osc_en   <= 1'b0;
            r_busy     <= 1'b0;
            r_edge_cnt <= '0;
          end else if (r_settle_cnt == SETTLE_LAST) begin
            r_state    <= S_GATE;
            r_gate_cnt <= '0;
          end else begin
            r_settle_cnt <= r_settle_cnt + 1'b1;
          end
        end
        S_GATE: begin
          if (abort) begin
            r_state    <= S_IDLE;
            r_osc_en   <= 1'b0;
            r_busy     <= 1'b0;
            r_edge_cnt <= '0;
            r_ovf      <= 1'b0;
          end else begin
            r_edge_cnt <= w_edge_next;
            r_ovf      <= w_ovf_next;
            // Closing edge latches the count including a rise seen in the final cycle.
            if (r_gate_cnt == GATE_LAST) begin
              r_count    <= w_edge_next;
              r_overflow <= w_ovf_next;
              r_done     <= 1'b1;
              r_osc_en   <= 1'b0;
              r_busy     <= 1'b0;
              r_state    <= S_IDLE;
            end else begin
              r_gate_cnt <= r_gate_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_osc_en <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign osc_en   = r_osc_en;
  assign busy     = r_busy;
  assign done     = r_done;
  assign count    = r_count;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_ring_osc_meter.sv
// Randomized scoreboard bench for ring_osc_meter, using a small gate and counter
// so that saturation is reachable.
module tb_ring_osc_meter;
  localparam int G    = 128;
  localparam int SET  = 8;
  localparam int S    = 3;
  localparam int CW   = 6;
  localparam int MAXC = (1 << CW) - 1;
  localparam int SPAN = SET + G + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          osc_in = 1'b0;
  logic          osc_en, busy, done, overflow;
  logic [CW-1:0] count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int cnt;
    int ovf;
    int dcyc;
  } exp_t;

  exp_t q[$];
  bit   wave[0:1023];

  ring_osc_meter #(
    .GATE_CYCLES  (G),
    .SETTLE_CYCLES(SET),
    .SYNC_STAGES  (S),
    .CNT_W        (CW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .osc_in  (osc_in),
    .osc_en  (osc_en),
    .busy    (busy),
    .done    (done),
    .count   (count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Waveform as sampled at successive clk edges: 0 square, 1 stuck low, 2 random bits.
  function automatic void gen(input int mode, input int per, input int len);
    int ph;
    ph = $urandom_range(0, per - 1);
    for (int j = 0; j < len; j++) begin
      case (mode)
        0:       wave[j] = (((j + ph) % per) < (per / 2));
        1:       wave[j] = 1'b0;
        default: wave[j] = 1'($urandom % 2);
      endcase
    end
  endfunction

  // The meter sees osc_in S edges late; the gate spans edges SET+1..SET+G after start.
  function automatic exp_t model(input int base, input int dcyc);
    exp_t e;
    int   edges;
    edges = 0;
    for (int k = SET + 1; k <= SET + G; k++)
      if (wave[base + k - S] && !wave[base + k - S - 1]) edges++;
    e.cnt  = (edges > MAXC) ? MAXC : edges;
    e.ovf  = (edges > MAXC) ? 1 : 0;
    e.dcyc = dcyc;
    return e;
  endfunction

  task automatic run_meas(input int n_meas, input int mode, input int per,
                          input int abort_at, input int restart_at, input int rst_at);
    int   n0;
    int   len;
    exp_t e;
    len = (n_meas + 1) * SPAN;
    gen(mode, per, len);
    n0 = cyc + 1;
    if (abort_at < 0 && rst_at < 0)
      for (int m = 0; m < n_meas; m++) begin
        e = model(m * SPAN, n0 + m * SPAN + SET + G);
        q.push_back(e);
      end
    for (int j = 0; j < len; j++) begin
      osc_in = wave[j];
      start  = (j <= (n_meas - 1) * SPAN) || (j == restart_at);
      abort  = (j == abort_at);
      if (abort_at >= 0 && j == abort_at + 1) begin
        chk("abort_busy", busy, 0);
        chk("abort_osc_en", osc_en, 0);
      end
      if (j == rst_at) begin
        start = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_osc_en", osc_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);
        chk("rst_overflow", overflow, 0);
        q.delete();
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
    for (int k = 0; k < 50 && q.size() != 0; k++) @(negedge clk);
    if (q.size() != 0) begin
      chk("done_timeout_pending", q.size(), 0);
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Monitor: pops an expectation whenever done is presented.
  initial begin
    int   run;
    int   lc;
    int   lo;
    exp_t e;
    run = 0;
    lc  = 0;
    lo  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        lc  = 0;
        lo  = 0;
        run = 0;
      end else begin
        chk("osc_en_eq_busy", osc_en, busy);
        if (busy) run++;
        if (done) begin
          if (q.size() == 0) begin
            chk("unexpected_done", done, 0);
          end else begin
            e = q.pop_front();
            chk("count", count, e.cnt);
            chk("overflow", overflow, e.ovf);
            chk("done_cycle", cyc, e.dcyc);
            chk("busy_cycles", run, SET + G);
            chk("osc_en_at_done", osc_en, 0);
          end
          lc  = count;
          lo  = overflow;
          run = 0;
        end else begin
          chk("count_stable", count, lc);
          chk("ovf_stable", overflow, lo);
          if (!busy) run = 0;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_osc_en", osc_en, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_count", count, 0);
    chk("reset_overflow", overflow, 0);
    #2 rst = 1'b0;
    @(negedge clk);

    run_meas(1, 0, 8, -1, -1, -1);
    run_meas(1, 1, 2, -1, -1, -1);
    run_meas(1, 0, 2, -1, -1, -1);
    run_meas(1, 0, 8, -1, -1, -1);
    for (int i = 0; i < 6; i++)
      run_meas(1, int'($urandom_range(0, 2)), int'($urandom_range(2, 12)), -1, -1, -1);
    run_meas(2, 0, 6, -1, -1, -1);
    run_meas(1, 2, 2, -1, SET + 1 + int'($urandom_range(10, 100)), -1);
    run_meas(1, 0, 8, SET + 1 + int'($urandom_range(0, G - 1)), -1, -1);
    run_meas(1, 0, 4, int'($urandom_range(1, SET)), -1, -1);

    start = 1'b1;
    abort = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("start_abort_idle_busy", busy, 0);
      chk("start_abort_idle_osc_en", osc_en, 0);
    end
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);

    run_meas(1, 0, 8, -1, -1, -1);
    run_meas(1, 0, 8, -1, -1, SET + 1 + int'($urandom_range(5, G - 5)));
    run_meas(1, 0, 8, -1, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
